// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter sharing one rggen register bus among HOSTS requesters.
// Define RGGEN_BUS_ARBITER_TIMEOUT_EN to end a stalled access with SLVERR after TIMEOUT_CYCLES.
module rggen_register_bus_arbiter #(
  parameter int unsigned HOSTS          = 2,
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [HOSTS-1:0]               i_host_valid,
  input  logic [2*HOSTS-1:0]             i_host_access,
  input  logic [ADDRESS_WIDTH*HOSTS-1:0] i_host_address,
  input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_write_data,
  input  logic [(BUS_WIDTH/8)*HOSTS-1:0] i_host_strobe,
  output logic [HOSTS-1:0]               o_host_ready,
  output logic [2*HOSTS-1:0]             o_host_status,
  output logic [BUS_WIDTH*HOSTS-1:0]     o_host_read_data,
  output logic [HOSTS-1:0]               o_grant,
  output logic                           o_bus_valid,
  output logic [1:0]                     o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]       o_bus_address,
  output logic [BUS_WIDTH-1:0]           o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_bus_strobe,
  input  logic                           i_bus_ready,
  input  logic [1:0]                     i_bus_status,
  input  logic [BUS_WIDTH-1:0]           i_bus_read_data
);

  localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned PTR_WIDTH    = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                   state_q;
  state_e                   state_d;
  logic [PTR_WIDTH-1:0]     ptr_q;
  logic [PTR_WIDTH-1:0]     ptr_d;
  logic [PTR_WIDTH-1:0]     owner_q;
  logic [PTR_WIDTH-1:0]     owner_d;
  logic [PTR_WIDTH-1:0]     pick;
  logic [PTR_WIDTH-1:0]     cand;
  logic                     any_valid;
  logic [HOSTS-1:0]         grant_q;
  logic [HOSTS-1:0]         grant_d;
  logic                     load;
  logic                     done;
  logic                     timeout;
  logic [1:0]               done_status;
  logic [BUS_WIDTH-1:0]     done_read_data;

  logic [1:0]               access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [STROBE_WIDTH-1:0]  strobe_q;

  logic [1:0]               host_access     [HOSTS];
  logic [ADDRESS_WIDTH-1:0] host_address    [HOSTS];
  logic [BUS_WIDTH-1:0]     host_write_data [HOSTS];
  logic [STROBE_WIDTH-1:0]  host_strobe     [HOSTS];

  // Per-host slicing of the flat request/response buses
  for (genvar g = 0; g < HOSTS; g++) begin : g_host
    assign host_access[g]     = i_host_access[2*g +: 2];
    assign host_address[g]    = i_host_address[ADDRESS_WIDTH*g +: ADDRESS_WIDTH];
    assign host_write_data[g] = i_host_write_data[BUS_WIDTH*g +: BUS_WIDTH];
    assign host_strobe[g]     = i_host_strobe[STROBE_WIDTH*g +: STROBE_WIDTH];

    assign o_host_ready[g]                         = done && (owner_q == PTR_WIDTH'(g));
    assign o_host_status[2*g +: 2]                 = o_host_ready[g] ? done_status : 2'b00;
    assign o_host_read_data[BUS_WIDTH*g +: BUS_WIDTH] = o_host_ready[g] ? done_read_data : '0;
  end

  // A watchdog expiry reports SLVERR with zero data; a real ready always wins
  assign done_status    = i_bus_ready ? i_bus_status : 2'b10;
  assign done_read_data = i_bus_ready ? i_bus_read_data : '0;

  // First requester at or after the round-robin pointer
  always_comb begin
    pick      = ptr_q;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < HOSTS; i++) begin
      cand = PTR_WIDTH'((32'(ptr_q) + i) % HOSTS);
      if (!any_valid && i_host_valid[cand]) begin
        any_valid = 1'b1;
        pick      = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = BUSY;
          owner_d = pick;
          grant_d = HOSTS'(1) << pick;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (i_bus_ready || timeout) begin
          done    = 1'b1;
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (32'(owner_q) == HOSTS - 1) ? '0 : owner_q + PTR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered bus payload, frozen for the whole BUSY phase
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else if (load) begin
      access_q     <= host_access[pick];
      address_q    <= host_address[pick];
      write_data_q <= host_write_data[pick];
      strobe_q     <= host_strobe[pick];
    end
  end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES);

  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if ((state_q == BUSY) && !i_bus_ready) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign timeout = (state_q == BUSY) && !i_bus_ready &&
                   (count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
  assign timeout               = 1'b0;
`endif

  assign o_grant          = grant_q;
  assign o_bus_valid      = (state_q == BUSY);
  assign o_bus_access     = access_q;
  assign o_bus_address    = address_q;
  assign o_bus_write_data = write_data_q;
  assign o_bus_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Self-checking bench for rggen_register_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_rggen_register_bus_arbiter;

  localparam int unsigned H  = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [H-1:0]  hval;
  logic [1:0]    hacc [H];
  logic [AW-1:0] hadr [H];
  logic [DW-1:0] hwd  [H];
  logic [SW-1:0] hstb [H];

  logic [2*H-1:0]  host_access;
  logic [AW*H-1:0] host_address;
  logic [DW*H-1:0] host_write_data;
  logic [SW*H-1:0] host_strobe;

  logic [H-1:0]    host_ready;
  logic [2*H-1:0]  host_status;
  logic [DW*H-1:0] host_read_data;
  logic [1:0]      h_stat  [H];
  logic [DW-1:0]   h_rdata [H];

  logic [H-1:0]  grant;
  logic          bus_valid;
  logic [1:0]    bus_access;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_write_data;
  logic [SW-1:0] bus_strobe;
  logic          bus_ready;
  logic [1:0]    bus_status;
  logic [DW-1:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < H; g++) begin : g_pack
    assign host_access[2*g +: 2]      = hacc[g];
    assign host_address[AW*g +: AW]   = hadr[g];
    assign host_write_data[DW*g +: DW] = hwd[g];
    assign host_strobe[SW*g +: SW]    = hstb[g];
    assign h_stat[g]                  = host_status[2*g +: 2];
    assign h_rdata[g]                 = host_read_data[DW*g +: DW];
  end

  rggen_register_bus_arbiter #(
    .HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_host_valid(hval),
    .i_host_access(host_access),
    .i_host_address(host_address),
    .i_host_write_data(host_write_data),
    .i_host_strobe(host_strobe),
    .o_host_ready(host_ready),
    .o_host_status(host_status),
    .o_host_read_data(host_read_data),
    .o_grant(grant),
    .o_bus_valid(bus_valid),
    .o_bus_access(bus_access),
    .o_bus_address(bus_address),
    .o_bus_write_data(bus_write_data),
    .o_bus_strobe(bus_strobe),
    .i_bus_ready(bus_ready),
    .i_bus_status(bus_status),
    .i_bus_read_data(bus_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    hval       = '0;
    bus_ready  = 1'b0;
    bus_status = 2'b00;
    bus_rdata  = '0;
    for (int k = 0; k < H; k++) begin
      hacc[k] = '0;
      hadr[k] = '0;
      hwd[k]  = '0;
      hstb[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n     = 1'b0;
    hval      = '1;
    bus_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      settle();
      n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid got %b exp 0", bus_valid); end
      n_tests++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant got %b exp 0", grant); end
      n_tests++; if (host_ready !== '0) begin n_fail++; $display("FAIL reset_host_ready got %b exp 0", host_ready); end
    end
    n_tests++; if (bus_address !== '0 || bus_write_data !== '0 || bus_access !== '0 || bus_strobe !== '0) begin
      n_fail++; $display("FAIL reset_bus_payload got %h/%h/%h/%h exp 0", bus_access, bus_address, bus_write_data, bus_strobe);
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_read();
    hval    = 2'b01;
    hacc[0] = 2'b00;
    hadr[0] = 8'h10;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) begin
        bus_ready  = 1'b1;
        bus_rdata  = 32'h1234_5678;
        bus_status = 2'b00;
        hval       = '0;
      end
      settle();
      n_tests++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL read_bus_valid c%0d got %b exp 1", c, bus_valid); end
      n_tests++; if (bus_address !== 8'h10) begin n_fail++; $display("FAIL read_address c%0d got %h exp 10", c, bus_address); end
      n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL read_grant c%0d got %b exp 01", c, grant); end
      n_tests++; if (host_ready !== ((c == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL read_host_ready c%0d got %b", c, host_ready); end
      n_tests++; if (h_rdata[1] !== '0 || h_stat[1] !== 2'b00) begin n_fail++; $display("FAIL read_host1_quiet c%0d got %h/%b exp 0", c, h_rdata[1], h_stat[1]); end
    end
    n_tests++; if (h_rdata[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data got %h exp 12345678", h_rdata[0]); end
    n_tests++; if (h_stat[0] !== 2'b00) begin n_fail++; $display("FAIL read_status got %b exp 00", h_stat[0]); end
    next_cycle();
    bus_ready = 1'b0;
    bus_rdata = '0;
    settle();
    n_tests++; if (bus_valid !== 1'b0 || grant !== '0) begin n_fail++; $display("FAIL read_release got %b/%b exp 0/00", bus_valid, grant); end
  endtask

  task automatic test_round_robin();
    logic [H-1:0] exp_g;
    logic         exp_v;
    do_reset();
    hval = '1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      bus_ready = (c % 3 == 2);
      bus_rdata = $urandom;
      if (c == 12) hval = '0;
      settle();
      exp_v = (c % 3 != 0);
      exp_g = exp_v ? (H'(1) << (((c - 1) / 3) % 2)) : '0;
      n_tests++; if (bus_valid !== exp_v) begin n_fail++; $display("FAIL rr_bus_valid c%0d got %b exp %b", c, bus_valid, exp_v); end
      n_tests++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant c%0d got %b exp %b", c, grant, exp_g); end
      n_tests++; if (host_ready !== (bus_ready ? exp_g : '0)) begin n_fail++; $display("FAIL rr_host_ready c%0d got %b exp %b", c, host_ready, bus_ready ? exp_g : '0); end
      if (c % 3 == 2) begin
        n_tests++; if (h_rdata[((c - 1) / 3) % 2] !== bus_rdata) begin n_fail++; $display("FAIL rr_read_data c%0d got %h exp %h", c, h_rdata[((c - 1) / 3) % 2], bus_rdata); end
      end
    end
    bus_ready = 1'b0;
  endtask

  task automatic test_write_hold();
    hval    = 2'b10;
    hacc[1] = 2'b10;
    hadr[1] = 8'h24;
    hwd[1]  = 32'hDEAD_BEEF;
    hstb[1] = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      hadr[1] = 8'h24 ^ 8'($urandom_range(1, 255));
      hwd[1]  = 32'hDEAD_BEEF ^ 32'($urandom_range(1, 32'h7fff_ffff));
      hstb[1] = 4'($urandom);
      if (c == 6) begin
        bus_ready = 1'b1;
        hval      = '0;
      end
      settle();
      n_tests++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL hold_bus_valid c%0d got %b exp 1", c, bus_valid); end
      n_tests++; if (bus_address !== 8'h24) begin n_fail++; $display("FAIL hold_address c%0d got %h exp 24", c, bus_address); end
      n_tests++; if (bus_write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hold_write_data c%0d got %h exp deadbeef", c, bus_write_data); end
      n_tests++; if (bus_strobe !== 4'hF || bus_access !== 2'b10) begin n_fail++; $display("FAIL hold_strobe_access c%0d got %h/%b exp f/10", c, bus_strobe, bus_access); end
      n_tests++; if (host_ready !== ((c == 6) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL hold_host_ready c%0d got %b", c, host_ready); end
    end
    next_cycle();
    bus_ready = 1'b0;
    settle();
    n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got %b exp 0", bus_valid); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    hval    = 2'b01;
    hadr[0] = 8'h30;
    next_cycle();
    next_cycle();
    settle();
    n_tests++; if (bus_valid !== 1'b1 || grant !== 2'b01) begin n_fail++; $display("FAIL mid_busy got %b/%b exp 1/01", bus_valid, grant); end
    rst_n = 1'b0;
    next_cycle();
    bus_ready = 1'b1;
    settle();
    n_tests++; if (host_ready !== '0) begin n_fail++; $display("FAIL mid_no_ready got %b exp 00", host_ready); end
    n_tests++; if (bus_valid !== 1'b0 || grant !== '0) begin n_fail++; $display("FAIL mid_dropped got %b/%b exp 0/00", bus_valid, grant); end
    rst_n     = 1'b1;
    bus_ready = 1'b0;
    hval      = 2'b11;
    next_cycle();
    bus_ready = 1'b1;
    hval      = '0;
    settle();
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL mid_pointer_reset got %b exp 01", grant); end
    n_tests++; if (host_ready !== 2'b01) begin n_fail++; $display("FAIL mid_after_ready got %b exp 01", host_ready); end
    next_cycle();
    bus_ready = 1'b0;
  endtask

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    idle_inputs();
    next_cycle();
    hval      = 2'b01;
    bus_rdata = 32'hA5A5_5A5A;
    for (int c = 1; c <= TO; c++) begin
      next_cycle();
      if (c == TO) hval = '0;
      settle();
      n_tests++; if (host_ready !== ((c == TO) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL timeout_ready c%0d got %b", c, host_ready); end
    end
    n_tests++; if (h_stat[0] !== 2'b10) begin n_fail++; $display("FAIL timeout_status got %b exp 10", h_stat[0]); end
    n_tests++; if (h_rdata[0] !== '0) begin n_fail++; $display("FAIL timeout_read_data got %h exp 0", h_rdata[0]); end
    next_cycle();
    settle();
    n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_release got %b exp 0", bus_valid); end
    idle_inputs();
  endtask
`endif

  // Transaction-level model: one owner at a time, winner chosen by rotating priority
  task automatic test_random();
    int            ptr = 0;
    int            owner = 0;
    int            age = 0;
    int            delay = 0;
    bit            busy = 1'b0;
    bit            found;
    int            h;
    logic [1:0]    m_acc;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wd;
    logic [SW-1:0] m_stb;
    logic [H-1:0]  exp_g;
    logic          exp_r;
    idle_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      hval = H'($urandom);
      for (int k = 0; k < H; k++) begin
        hacc[k] = 2'($urandom);
        hadr[k] = AW'($urandom);
        hwd[k]  = $urandom;
        hstb[k] = SW'($urandom);
      end
      bus_status = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      bus_rdata  = $urandom;
      bus_ready  = busy ? (age >= delay) : 1'($urandom);
      settle();
      exp_g = busy ? (H'(1) << owner) : '0;
      n_tests++; if (bus_valid !== busy) begin n_fail++; $display("FAIL rnd_bus_valid c%0d got %b exp %b", c, bus_valid, busy); end
      n_tests++; if (grant !== exp_g) begin n_fail++; $display("FAIL rnd_grant c%0d got %b exp %b", c, grant, exp_g); end
      if (busy) begin
        n_tests++; if ({bus_access, bus_address, bus_write_data, bus_strobe} !== {m_acc, m_adr, m_wd, m_stb}) begin
          n_fail++; $display("FAIL rnd_payload c%0d got %h %h %h %h exp %h %h %h %h", c,
                             bus_access, bus_address, bus_write_data, bus_strobe, m_acc, m_adr, m_wd, m_stb);
        end
      end
      for (int k = 0; k < H; k++) begin
        exp_r = busy && bus_ready && (k == owner);
        n_tests++; if (host_ready[k] !== exp_r) begin n_fail++; $display("FAIL rnd_ready c%0d h%0d got %b exp %b", c, k, host_ready[k], exp_r); end
        n_tests++; if (h_rdata[k] !== (exp_r ? bus_rdata : '0) || h_stat[k] !== (exp_r ? bus_status : 2'b00)) begin
          n_fail++; $display("FAIL rnd_response c%0d h%0d got %h/%b exp %h/%b", c, k, h_rdata[k], h_stat[k],
                             exp_r ? bus_rdata : '0, exp_r ? bus_status : 2'b00);
        end
      end
      if (busy) begin
        if (bus_ready) begin
          busy = 1'b0;
          ptr  = (owner + 1) % H;
        end else begin
          age++;
        end
      end else begin
        found = 1'b0;
        for (int i = 0; i < H; i++) begin
          h = (ptr + i) % H;
          if (!found && hval[h]) begin
            found = 1'b1;
            owner = h;
            m_acc = hacc[h];
            m_adr = hadr[h];
            m_wd  = hwd[h];
            m_stb = hstb[h];
          end
        end
        if (found) begin
          busy  = 1'b1;
          age   = 0;
          delay = $urandom_range(0, 2);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_hold();
    test_reset_mid();
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
